// File: rtl/mnist_input_binarizer_pkg.sv
// Shared constants and state type for the MNIST input path.
// The pixel/threshold defaults describe the real 28x28 network input.
package mnist_io_pkg;
   localparam int MNIST_PIXELS = 784;
   localparam int MNIST_PIX_W  = 8;
   localparam int MNIST_THRESH = 128;
   localparam int IDX_W        = $clog2(MNIST_PIXELS);

   typedef enum logic {FILL, HOLD} state_e;
endpackage

// File: rtl/mnist_input_binarizer_if.sv
// Pixel-stream input and packed-frame output handshakes of the binarizer.
// slave = the binarizer itself, master = the side that feeds pixels and drains frames.
interface mnist_input_binarizer_if #(
   parameter int PIXELS = 784,
   parameter int PIX_W  = 8
) ();
   logic              s_valid;
   logic              s_ready;
   logic [PIX_W-1:0]  s_data;
   logic              s_last;
   logic              m_valid;
   logic              m_ready;
   logic [PIXELS-1:0] m_data;

   modport slave  (input  s_valid, s_data, s_last, m_ready,
                   output s_ready, m_valid, m_data);
   modport master (output s_valid, s_data, s_last, m_ready,
                   input  s_ready, m_valid, m_data);
endinterface

// File: rtl/mnist_input_binarizer.sv
// Thresholds a pixel stream to 1 bit per pixel and packs each frame into a
// double-buffered (assembly + output register) vector for the layer-0 neurons.
module mnist_input_binarizer
   import mnist_io_pkg::*;
#(
   parameter int PIXELS = MNIST_PIXELS,
   parameter int PIX_W  = MNIST_PIX_W,
   parameter int THRESH = MNIST_THRESH
) (
   input  logic                     clk,
   input  logic                     rst,
   mnist_input_binarizer_if.slave   bus,
   output logic                     err_len,
   output logic [15:0]              frame_cnt
);
   localparam int IW = (PIXELS > 1) ? $clog2(PIXELS) : 1;

   state_e            state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [PIXELS-1:0] asm_q, asm_d, asm_set;
   logic [PIXELS-1:0] mdata_q, mdata_d, load_val;
   logic              mvalid_q, mvalid_d;
   logic              err_q, err_d;
   logic [15:0]       cnt_q, cnt_d;
   logic              accept, pix_bit, last_idx, out_free, load;

   assign bus.s_ready = !rst && (state_q == FILL);
   assign accept      = bus.s_valid && bus.s_ready;
   assign pix_bit     = (bus.s_data >= PIX_W'(THRESH));
   assign last_idx    = (idx_q == IW'(PIXELS - 1));
   assign out_free    = !mvalid_q || bus.m_ready;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      asm_d    = asm_q;
      mdata_d  = mdata_q;
      mvalid_d = mvalid_q;
      err_d    = 1'b0;
      cnt_d    = cnt_q;
      load     = 1'b0;
      load_val = asm_q;
      asm_set  = asm_q;
      asm_set[idx_q] = pix_bit;

      if (mvalid_q && bus.m_ready)
         mvalid_d = 1'b0;

      case (state_q)
         FILL: begin
            if (accept) begin
               if (last_idx) begin
                  // Frame complete; a missing s_last is flagged but the frame is kept.
                  idx_d = '0;
                  err_d = !bus.s_last;
                  asm_d = '0;
                  if (out_free) begin
                     load     = 1'b1;
                     load_val = asm_set;
                  end else begin
                     asm_d   = asm_set;
                     state_d = HOLD;
                  end
               end else if (bus.s_last) begin
                  idx_d = '0;
                  asm_d = '0;
                  err_d = 1'b1;
               end else begin
                  asm_d = asm_set;
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         HOLD: begin
            if (bus.m_ready) begin
               load     = 1'b1;
               load_val = asm_q;
               asm_d    = '0;
               state_d  = FILL;
            end
         end
         default: state_d = FILL;
      endcase

      if (load) begin
         mdata_d  = load_val;
         mvalid_d = 1'b1;
         cnt_d    = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= FILL;
         idx_q    <= '0;
         asm_q    <= '0;
         mdata_q  <= '0;
         mvalid_q <= 1'b0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         asm_q    <= asm_d;
         mdata_q  <= mdata_d;
         mvalid_q <= mvalid_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
      end
   end

   assign bus.m_valid = mvalid_q;
   assign bus.m_data  = mdata_q;
   assign err_len     = err_q;
   assign frame_cnt   = cnt_q;
endmodule

// File: tb/tb_mnist_input_binarizer.sv
// Directed bench: a queue-based frame model checks the 16-pixel instance every
// cycle; literal expectations pin the model and the 4-pixel threshold case.
module tb_mnist_input_binarizer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   mnist_input_binarizer_if #(.PIXELS(16), .PIX_W(8)) b16 ();
   mnist_input_binarizer_if #(.PIXELS(4),  .PIX_W(8)) b4 ();
   logic        err16, err4;
   logic [15:0] cnt16, cnt4;

   mnist_input_binarizer #(.PIXELS(16), .PIX_W(8), .THRESH(128)) u16 (
      .clk(clk), .rst(rst), .bus(b16), .err_len(err16), .frame_cnt(cnt16));
   mnist_input_binarizer #(.PIXELS(4), .PIX_W(8), .THRESH(128)) u4 (
      .clk(clk), .rst(rst), .bus(b4), .err_len(err4), .frame_cnt(cnt4));

   task automatic chk_b(string nm, logic act, logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk_w(string nm, logic [15:0] act, logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference: pixels collect in a queue; a full queue becomes a frame that
   // goes to the output if it is free, otherwise waits as a single pending frame.
   bit          mq[$];
   logic [15:0] m_out  = '0;
   logic [15:0] m_pend = '0;
   bit          m_ov   = 1'b0;
   bit          m_pv   = 1'b0;
   bit          m_err  = 1'b0;
   logic [15:0] m_cnt  = '0;
   bit          live   = 1'b0;

   always @(posedge clk) begin : model
      logic [15:0] v;
      logic [15:0] nv;
      bit          load;
      bit          free;
      if (rst) begin
         mq.delete();
         m_out = '0; m_pend = '0; m_ov = 1'b0; m_pv = 1'b0;
         m_err = 1'b0; m_cnt = '0; live = 1'b1;
      end else begin
         load  = 1'b0;
         nv    = '0;
         v     = '0;
         free  = !m_ov || b16.m_ready;
         m_err = 1'b0;
         if (m_pv) begin
            if (b16.m_ready) begin
               load = 1'b1; nv = m_pend; m_pv = 1'b0;
            end
         end else if (b16.s_valid) begin
            mq.push_back(b16.s_data >= 8'd128);
            if (mq.size() == 16) begin
               for (int i = 0; i < 16; i++) v[i] = mq[i];
               m_err = !b16.s_last;
               mq.delete();
               if (free) begin
                  load = 1'b1; nv = v;
               end else begin
                  m_pend = v; m_pv = 1'b1;
               end
            end else if (b16.s_last) begin
               mq.delete();
               m_err = 1'b1;
            end
         end
         if (load) begin
            m_out = nv; m_ov = 1'b1; m_cnt = m_cnt + 16'd1;
         end else if (b16.m_ready) begin
            m_ov = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (live) begin
         chk_b("s_ready", b16.s_ready, !rst && !m_pv);
         chk_b("m_valid", b16.m_valid, m_ov);
         if (m_ov) chk_w("m_data", b16.m_data, m_out);
         chk_b("err_len", err16, m_err);
         chk_w("frame_cnt", cnt16, m_cnt);
      end
   end

   task automatic cyc(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic px16(logic [7:0] d, logic l);
      b16.s_valid = 1'b1; b16.s_data = d; b16.s_last = l;
      cyc(1);
   endtask

   task automatic px4(logic [7:0] d, logic l);
      b4.s_valid = 1'b1; b4.s_data = d; b4.s_last = l;
      cyc(1);
   endtask

   task automatic frame16(logic [15:0] pat, logic last_ok);
      for (int i = 0; i < 16; i++)
         px16(pat[i] ? 8'd255 : 8'd0, (i == 15) && last_ok);
      b16.s_valid = 1'b0; b16.s_last = 1'b0;
   endtask

   initial begin
      b16.s_valid = 1'b0; b16.s_data = '0; b16.s_last = 1'b0; b16.m_ready = 1'b0;
      b4.s_valid  = 1'b0; b4.s_data  = '0; b4.s_last  = 1'b0; b4.m_ready  = 1'b0;
      rst = 1'b1;
      cyc(2);
      chk_b("rst_m_valid", b16.m_valid, 1'b0);
      chk_w("rst_m_data", b16.m_data, 16'h0000);
      chk_w("rst_frame_cnt", cnt16, 16'd0);
      chk_b("rst_err_len", err16, 1'b0);
      chk_b("rst_s_ready", b16.s_ready, 1'b0);
      rst = 1'b0;
      #1;
      chk_b("post_rst_s_ready", b16.s_ready, 1'b1);

      // back-to-back alternating frames, always-ready sink
      b16.m_ready = 1'b1;
      frame16(16'hAAAA, 1'b1);
      chk_b("t1_valid_a", b16.m_valid, 1'b1);
      chk_w("t1_data_a", b16.m_data, 16'hAAAA);
      chk_w("t1_cnt_a", cnt16, 16'd1);
      frame16(16'hAAAA, 1'b1);
      chk_b("t1_valid_b", b16.m_valid, 1'b1);
      chk_w("t1_data_b", b16.m_data, 16'hAAAA);
      chk_w("t1_cnt_b", cnt16, 16'd2);
      chk_b("t1_s_ready", b16.s_ready, 1'b1);

      // threshold boundary on the 4-pixel instance
      b4.m_ready = 1'b1;
      px4(8'd127, 1'b0);
      px4(8'd128, 1'b0);
      px4(8'd255, 1'b0);
      px4(8'd0,   1'b1);
      b4.s_valid = 1'b0; b4.s_last = 1'b0;
      chk_b("t2_valid", b4.m_valid, 1'b1);
      chk_w("t2_data", {12'h000, b4.m_data}, 16'h0006);
      chk_w("t2_cnt", cnt4, 16'd1);
      chk_b("t2_err", err4, 1'b0);

      // backpressure: second frame parks in HOLD
      b16.m_ready = 1'b0;
      cyc(2);
      frame16(16'h1234, 1'b1);
      chk_b("t3_valid_a", b16.m_valid, 1'b1);
      chk_w("t3_data_a", b16.m_data, 16'h1234);
      frame16(16'hBEEF, 1'b1);
      chk_b("t3_hold_ready", b16.s_ready, 1'b0);
      cyc(3);
      chk_b("t3_hold_ready2", b16.s_ready, 1'b0);
      chk_w("t3_data_held", b16.m_data, 16'h1234);
      b16.m_ready = 1'b1;
      cyc(1);
      b16.m_ready = 1'b0;
      chk_w("t3_data_b", b16.m_data, 16'hBEEF);
      chk_b("t3_valid_b", b16.m_valid, 1'b1);
      chk_w("t3_cnt", cnt16, 16'd4);
      chk_b("t3_ready_back", b16.s_ready, 1'b1);
      b16.m_ready = 1'b1;
      cyc(1);
      chk_b("t3_drained", b16.m_valid, 1'b0);

      // early s_last at pixel 5
      for (int i = 0; i < 6; i++) px16(8'd255, i == 5);
      b16.s_valid = 1'b0; b16.s_last = 1'b0;
      chk_b("t4_err", err16, 1'b1);
      chk_b("t4_no_valid", b16.m_valid, 1'b0);
      cyc(1);
      chk_b("t4_err_gone", err16, 1'b0);
      frame16(16'h8000, 1'b1);
      chk_w("t4_data", b16.m_data, 16'h8000);
      chk_w("t4_cnt", cnt16, 16'd5);

      // missing s_last: frame kept, next pixel starts a new frame
      frame16(16'h00F0, 1'b0);
      chk_b("t5_err", err16, 1'b1);
      chk_b("t5_valid", b16.m_valid, 1'b1);
      chk_w("t5_data", b16.m_data, 16'h00F0);
      frame16(16'h0003, 1'b1);
      chk_w("t5_next", b16.m_data, 16'h0003);
      chk_b("t5_err_clear", err16, 1'b0);
      chk_w("t5_cnt", cnt16, 16'd7);

      // reset while a frame is held
      b16.m_ready = 1'b0;
      cyc(2);
      frame16(16'h0F0F, 1'b1);
      frame16(16'hF0F0, 1'b1);
      chk_b("t6_in_hold", b16.s_ready, 1'b0);
      rst = 1'b1;
      cyc(1);
      chk_b("t6_valid_drop", b16.m_valid, 1'b0);
      chk_b("t6_ready_in_rst", b16.s_ready, 1'b0);
      rst = 1'b0;
      #1;
      chk_b("t6_ready_after", b16.s_ready, 1'b1);
      chk_w("t6_cnt_zero", cnt16, 16'd0);
      b16.m_ready = 1'b1;
      frame16(16'h5A5A, 1'b1);
      chk_b("t6_valid", b16.m_valid, 1'b1);
      chk_w("t6_data", b16.m_data, 16'h5A5A);
      chk_w("t6_cnt", cnt16, 16'd1);

      cyc(3);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/mnist_input_binarizer.md
Name: mnist_input_binarizer

Overview:
Upstream feeder for the layer-0 LUT neurons of the MNIST network. It accepts a stream of 8-bit grayscale pixels over a valid/ready handshake and thresholds each pixel to 1 bit. It packs one frame of PIXELS bits into a vector and presents that vector, registered and handshaked, to the layer-0 fan-in wiring. It is double-buffered (assembly register plus output register), so the next frame streams in while the current one is held for consumption.

Parameters:
PIXELS, 784, pixels per frame; output vector width.
PIX_W, 8, input pixel width.
THRESH, 128, binarization threshold; bit = (pixel >= THRESH), unsigned compare.

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
s_valid  in  1  pixel valid
s_ready  out  1  block can accept a pixel this cycle
s_data  in  PIX_W  pixel value, unsigned
s_last  in  1  marks final pixel of a frame
m_valid  out  1  frame vector valid
m_ready  in  1  downstream consumes frame
m_data  out  PIXELS  packed frame; bit i = binarized pixel i (pixel 0 is the first pixel received)
err_len  out  1  one-cycle pulse on frame-length mismatch
frame_cnt  out  16  frames delivered to output register, wraps at 2^16

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: m_valid=0, m_data=0, err_len=0, frame_cnt=0, pixel index=0, assembly register=0, state=FILL. s_ready=0 while rst=1.
- Pixel acceptance: a pixel is accepted on a cycle with s_valid && s_ready. Its binarized bit is written to assembly bit [idx], then idx increments. idx width is clog2(PIXELS).
- State FILL: s_ready=1. Accepting the pixel at idx=PIXELS-1 completes the frame.
  - If the output register is free, it is loaded with the completed frame, including the final bit, on that clock edge. Free means m_valid=0, or m_valid && m_ready in the same cycle. m_valid=1 the next cycle. idx returns to 0 and the state stays FILL.
  - Otherwise the frame stays in the assembly register. The state goes to HOLD and idx returns to 0.
- State HOLD: s_ready=0. On any cycle with m_ready=1, the output register is loaded from the assembly register and the state returns to FILL. m_valid stays 1 because a new frame replaces the consumed one.
- Output: m_valid clears on m_ready when no new frame is loading that cycle. m_data is stable while m_valid && !m_ready.
- Latency: 1 cycle from acceptance of the last pixel to m_valid, when the output register is free.
- Throughput: 1 pixel/cycle sustained when m_ready=1; no bubble between frames.
- Early s_last (s_last=1 at idx<PIXELS-1):
  - the pixel is accepted and the partial frame is discarded;
  - idx returns to 0 and the assembly register is cleared;
  - err_len pulses the next cycle;
  - the output register and frame_cnt are unaffected.
- Missing s_last (s_last=0 at idx=PIXELS-1): the frame completes normally and err_len pulses the next cycle. The next pixel starts a new frame.
- frame_cnt increments on every load of the output register.
- Reset mid-frame or in HOLD: the partial or held frame is dropped and m_valid drops. All state returns to reset values on the next edge.
- Assembly-register bits not written in the current frame hold 0, because the register is cleared on each frame start.

Decomposition:
- Shared package mnist_io_pkg: MNIST_PIXELS=784, MNIST_PIX_W=8, MNIST_THRESH=128, IDX_W=$clog2(MNIST_PIXELS), state enum {FILL, HOLD}.
- No sub-module. The comparator is one inline expression, and the FILL/HOLD control, index counter and two registers fit in one module.

Test Plan:
1. Two back-to-back frames at PIXELS=16, THRESH=128, pixels alternating 0/255, s_last at pixel 15, m_ready=1:
   - m_valid rises 1 cycle after pixel 15 both times;
   - m_data=16'hAAAA both times, with pixel 0 in bit 0;
   - frame_cnt=2; s_ready never drops.
2. Threshold boundary: pixels 127, 128, 255, 0 at PIXELS=4 -> m_data=4'b0110.
3. Backpressure with m_ready=0, two frames sent:
   - first frame loads the output register;
   - second frame stalls in HOLD with s_ready=0;
   - m_ready pulses for 1 cycle -> m_data switches to frame 2, s_ready=1 next cycle, frame_cnt=2.
4. Early s_last at pixel 5 of 16 -> err_len pulses once, no m_valid. The next full 16-pixel frame is delivered correctly, with no stale bits from the partial frame.
5. Missing s_last at pixel 15 -> frame delivered, err_len pulses once, pixel 16 becomes bit 0 of the next frame.
6. rst asserted during HOLD -> next cycle m_valid=0, s_ready=0 while rst=1. After release s_ready=1, frame_cnt=0, and a fresh frame is delivered normally.
